// File: rtl/wb_cmd_master.sv
// wb_cmd_master: command FIFO feeding a Wishbone classic initiator.
// Each queued command runs as one bus cycle and gives one response.
// Ports: clk, rst (async, active-high)
//   cmd_*  : command push (valid/ready, we, adr, dat, sel)
//   rsp_*  : response pop (valid/ready, dat, err, timeout)
//   wb_*   : Wishbone classic initiator signals
//   busy   : FIFO non-empty or transfer in progress
// Optional: define WB_CMD_MASTER_TIMEOUT_EN for the request timeout.
module wb_cmd_master #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   cmd_t        fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        rdy_en_q;
   cmd_t        bus_q, bus_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic        rsp_err_q, rsp_err_d;
   logic        fifo_empty, fifo_full;
   logic        push, pop, tmo_hit;
   cmd_t        cmd_in;
   logic        unused_adr_bits;

   // Bus is word-addressed; byte offset is dropped at the FIFO input.
   assign unused_adr_bits = ^cmd_adr[1:0];

   assign cmd_in.we  = cmd_we;
   assign cmd_in.adr = {cmd_adr[31:2], 2'b00};
   assign cmd_in.dat = cmd_we ? cmd_dat : 32'h0;
   assign cmd_in.sel = cmd_sel;

   // Extra MSB on the pointers separates full from empty.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // rdy_en_q keeps cmd_ready low in reset and until the first edge after.
   assign cmd_ready = rdy_en_q & ~fifo_full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == IDLE) & ~fifo_empty;

   assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= cmd_in;
      end
   end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       rsp_tmo_q, rsp_tmo_d;

   // Counter value N means N full REQ cycles have elapsed before this edge.
   assign tmo_hit = (state_q == REQ) &&
                    (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      rsp_tmo_d = rsp_tmo_q;
      if (pop) begin
         tmo_cnt_d = 8'd0;
      end else if (state_q == REQ) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
      if (state_q == REQ) begin
         if (wb_ack_i | wb_err_i) begin
            rsp_tmo_d = 1'b0;
         end else if (tmo_hit) begin
            rsp_tmo_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= 8'd0;
         rsp_tmo_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         rsp_tmo_q <= rsp_tmo_d;
      end
   end

   assign rsp_timeout = rsp_tmo_q;
`else
   assign tmo_hit     = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!fifo_empty) state_d = REQ;
         REQ:  if (wb_ack_i | wb_err_i | tmo_hit) state_d = RSP;
         RSP:  if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      wb_cyc_o  = (state_q == REQ);
      wb_stb_o  = (state_q == REQ);
      rsp_valid = (state_q == RSP);
      busy      = ~fifo_empty | (state_q != IDLE);
   end

   // Bus and response datapath; err outranks ack, ack outranks timeout.
   always_comb begin
      bus_d     = bus_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      if (pop) begin
         bus_d = fifo_mem[rd_ptr_q[AW-1:0]];
      end
      if (state_q == REQ) begin
         if (wb_err_i) begin
            rsp_err_d = 1'b1;
            rsp_dat_d = 32'h0;
         end else if (wb_ack_i) begin
            rsp_err_d = 1'b0;
            rsp_dat_d = bus_q.we ? 32'h0 : wb_dat_i;
         end else if (tmo_hit) begin
            rsp_err_d = 1'b1;
            rsp_dat_d = 32'h0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rdy_en_q  <= 1'b0;
         bus_q     <= '0;
         rsp_dat_q <= 32'h0;
         rsp_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rdy_en_q  <= 1'b1;
         bus_q     <= bus_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign wb_adr_o = bus_q.adr;
   assign wb_dat_o = bus_q.dat;
   assign wb_sel_o = bus_q.sel;
   assign wb_we_o  = bus_q.we;
   assign rsp_dat  = rsp_dat_q;
   assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench for wb_cmd_master.
// Scripted responder plus hand-computed expected values.
module tb_wb_cmd_master;

   localparam int M_ACK  = 0;
   localparam int M_ERR  = 1;
   localparam int M_BOTH = 2;
   localparam int M_NONE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        busy;

   int          n_chk = 0;
   int          n_err = 0;

   int          r_mode = M_ACK;
   int          r_wait = 0;
   logic [31:0] r_data = '0;
   logic        r_from_adr = 1'b0;
   logic        r_spur = 1'b0;

   wb_cmd_master #(
      .FIFO_DEPTH    (4),
      .TIMEOUT_CYCLES(10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_adr    (cmd_adr),
      .cmd_dat    (cmd_dat),
      .cmd_sel    (cmd_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_dat    (rsp_dat),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_sel_o   (wb_sel_o),
      .wb_we_o    (wb_we_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Responder: changes its outputs on the falling edge only.
   initial begin
      int wcnt;
      wcnt = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = '0;
      forever begin
         @(negedge clk);
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_dat_i = '0;
         if (wb_cyc_o && wb_stb_o) begin
            if (wcnt >= r_wait && r_mode != M_NONE) begin
               wb_ack_i = (r_mode != M_ERR);
               wb_err_i = (r_mode != M_ACK);
               wb_dat_i = r_from_adr ? (wb_adr_o ^ 32'h5A5A0000) : r_data;
            end
            wcnt++;
         end else begin
            wcnt = 0;
            if (r_spur) begin
               wb_ack_i = 1'b1;
               wb_err_i = 1'b1;
               wb_dat_i = 32'hFFFFFFFF;
            end
         end
      end
   end

   task automatic push(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = a;
      cmd_dat   = d;
      cmd_sel   = s;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic watch_req(input int limit, output int n,
                            output logic [31:0] a, output logic [31:0] d,
                            output logic w, output logic [3:0] s,
                            output logic stable);
      int guard;
      guard  = 0;
      n      = 0;
      a      = '0;
      d      = '0;
      w      = 1'b0;
      s      = '0;
      stable = 1'b1;
      while (guard < limit + 50) begin
         @(negedge clk);
         guard++;
         if (wb_cyc_o && wb_stb_o) begin
            if (n > 0 && (a != wb_adr_o || d != wb_dat_o ||
                          w != wb_we_o || s != wb_sel_o))
               stable = 1'b0;
            n++;
            a = wb_adr_o;
            d = wb_dat_o;
            w = wb_we_o;
            s = wb_sel_o;
            if (n == limit) break;
         end else if (n > 0) begin
            break;
         end
      end
   endtask

   task automatic take_rsp(input string tag, input logic [31:0] edat,
                           input logic eerr, input logic etmo);
      int g;
      g = 0;
      while (!rsp_valid && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_dat"}, rsp_dat, edat);
      chk({tag, "_err"}, 32'(rsp_err), 32'(eerr));
      chk({tag, "_tmo"}, 32'(rsp_timeout), 32'(etmo));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      logic [3:0]  s;
      logic        st;
      logic [31:0] got [5];
      int          k;
      int          g;
      logic        seen;

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_rspv", 32'(rsp_valid), 32'd0);
      chk("rst_adr", wb_adr_o, 32'd0);
      rst = 1'b0;
      #1 chk("ready_pre_edge", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1 chk("ready_post_edge", 32'(cmd_ready), 32'd1);

      // Write, ack after 2 wait states
      r_mode = M_ACK;
      r_wait = 2;
      push(1'b1, 32'h00001003, 32'hDEADBEEF, 4'hF);
      watch_req(100, n, a, d, w, s, st);
      chk("wr_cycles", 32'(n), 32'd3);
      chk("wr_adr", a, 32'h00001000);
      chk("wr_we", 32'(w), 32'd1);
      chk("wr_dat", d, 32'hDEADBEEF);
      chk("wr_sel", 32'(s), 32'hF);
      chk("wr_stable", 32'(st), 32'd1);
      take_rsp("wr", 32'h0, 1'b0, 1'b0);

      // Read, immediate ack with data
      r_wait = 0;
      r_data = 32'h12345678;
      push(1'b0, 32'h00001000, 32'hFFFFFFFF, 4'h3);
      watch_req(100, n, a, d, w, s, st);
      chk("rd_cycles", 32'(n), 32'd1);
      chk("rd_dat_o", d, 32'h0);
      chk("rd_we", 32'(w), 32'd0);
      chk("rd_sel", 32'(s), 32'h3);
      chk("rd_cyc_after", 32'(wb_cyc_o), 32'd0);
      chk("rd_stb_after", 32'(wb_stb_o), 32'd0);
      chk("rd_rspv", 32'(rsp_valid), 32'd1);
      repeat (3) @(negedge clk);
      chk("rd_hold_dat", rsp_dat, 32'h12345678);
      take_rsp("rd", 32'h12345678, 1'b0, 1'b0);

      // ack and err together on a read
      r_mode = M_BOTH;
      r_data = 32'hCAFEF00D;
      push(1'b0, 32'h00002000, 32'h0, 4'hF);
      watch_req(100, n, a, d, w, s, st);
      take_rsp("ackerr", 32'h0, 1'b1, 1'b0);

      // err only on a write
      r_mode = M_ERR;
      push(1'b1, 32'h00003004, 32'h11112222, 4'h1);
      watch_req(100, n, a, d, w, s, st);
      chk("werr_adr", a, 32'h00003004);
      take_rsp("werr", 32'h0, 1'b1, 1'b0);

      // ack/err while idle must be ignored
      r_spur = 1'b1;
      repeat (4) @(negedge clk);
      r_spur = 1'b0;
      @(negedge clk);
      chk("spur_rspv", 32'(rsp_valid), 32'd0);
      chk("spur_busy", 32'(busy), 32'd0);

      // Fill: 1 in FSM + 4 in FIFO, rsp held off
      r_mode     = M_ACK;
      r_wait     = 0;
      r_from_adr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fill_ready", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b1;
         cmd_we    = 1'b0;
         cmd_adr   = 32'h00004000 + 32'(i * 4);
         cmd_sel   = 4'hF;
         @(posedge clk);
      end
      @(negedge clk);
      cmd_adr = 32'h00005000;
      chk("full_ready", 32'(cmd_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      chk("full_rspv", 32'(rsp_valid), 32'd1);
      repeat (3) @(negedge clk);
      chk("full_ready_hold", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      k = 0;
      g = 0;
      while (g < 200) begin
         if (rsp_valid) begin
            if (k < 5) got[k] = rsp_dat;
            k++;
         end
         if (k >= 5 && !busy) break;
         @(negedge clk);
         g++;
      end
      rsp_ready  = 1'b0;
      r_from_adr = 1'b0;
      chk("drain_count", 32'(k), 32'd5);
      for (int i = 0; i < 5; i++)
         chk("drain_order", got[i],
             (32'h00004000 + 32'(i * 4)) ^ 32'h5A5A0000);

      // Responder never answers
      r_mode = M_NONE;
      push(1'b0, 32'h00006000, 32'h0, 4'hF);
      watch_req(1000, n, a, d, w, s, st);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      chk("tmo_cycles", 32'(n), 32'd10);
      take_rsp("tmo", 32'h0, 1'b1, 1'b1);
`else
      chk("notmo_cycles", 32'(n), 32'd1000);
      chk("notmo_cyc", 32'(wb_cyc_o), 32'd1);
      chk("notmo_rspv", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
`endif

      // Reset mid-REQ with 2 entries queued
      r_mode = M_NONE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_we    = 1'b0;
         cmd_adr   = 32'h00008000 + 32'(i * 4);
         cmd_sel   = 4'hF;
         @(posedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("arst_stb", 32'(wb_stb_o), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd0);
      chk("arst_adr", wb_adr_o, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (wb_cyc_o || rsp_valid) seen = 1'b1;
      end
      chk("post_rst_quiet", 32'(seen), 32'd0);

      r_mode = M_ACK;
      r_data = 32'h0BADCAFE;
      push(1'b0, 32'h00007000, 32'h0, 4'hF);
      watch_req(100, n, a, d, w, s, st);
      chk("post_rst_cycles", 32'(n), 32'd1);
      chk("post_rst_adr", a, 32'h00007000);
      take_rsp("post_rst", 32'h0BADCAFE, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
